// File: rtl/rate_change_cfg_ctrl_if.sv
// Bundle of request, stream-snoop and settings-bus signals for rate_change_cfg_ctrl.
//   slave  : the sequencer side (takes requests and snoops, drives hold/clear/settings/status)
//   master : the control / environment side (drives requests and snoops, observes outputs)
interface rate_change_cfg_ctrl_if;
  // rate-change request
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_n;
  logic [15:0] req_m;
  logic [31:0] req_config;
  // snoop of axi_rate_change input and output streams
  logic        i_tvalid;
  logic        i_tready;
  logic        i_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tlast;
  // controls toward upstream and axi_rate_change
  logic        hold;
  logic        clear;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  // status
  logic        done;
  logic        err_range;
  logic        err_timeout;
  logic        busy;

  modport slave (
    input  req_valid, req_n, req_m, req_config,
    input  i_tvalid, i_tready, i_tlast, o_tvalid, o_tready, o_tlast,
    output req_ready, hold, clear, set_stb, set_addr, set_data,
    output done, err_range, err_timeout, busy
  );

  modport master (
    output req_valid, req_n, req_m, req_config,
    output i_tvalid, i_tready, i_tlast, o_tvalid, o_tready, o_tlast,
    input  req_ready, hold, clear, set_stb, set_addr, set_data,
    input  done, err_range, err_timeout, busy
  );
endinterface

// File: rtl/rate_change_cfg_ctrl.sv
// rate_change_cfg_ctrl: reconfiguration sequencer for axi_rate_change.
// Accepts an N/M/CONFIG request, range-checks it, holds the upstream stream at a packet
// boundary, waits for both streams to be quiet, pulses clear, then writes N, M and CONFIG
// over the settings bus on consecutive cycles.
// Ports:
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   cfg_bus  : rate_change_cfg_ctrl_if.slave (request port, stream snoops, hold/clear,
//              settings bus set_stb/set_addr/set_data, done/err_range/err_timeout/busy)
// Optional feature: define RATE_CFG_TIMEOUT_EN to add a DRAIN timeout that raises sticky
// err_timeout and forces the sequence on; otherwise DRAIN waits indefinitely.
module rate_change_cfg_ctrl #(
  parameter int unsigned MAX_N          = 16,
  parameter int unsigned MAX_M          = 16,
  parameter logic [7:0]  SR_N_ADDR      = 8'd0,
  parameter logic [7:0]  SR_M_ADDR      = 8'd1,
  parameter logic [7:0]  SR_CONFIG_ADDR = 8'd2,
  parameter int unsigned CLEAR_CYCLES   = 2,
  parameter int unsigned QUIET_CYCLES   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input logic                   clk,
  input logic                   reset,
  rate_change_cfg_ctrl_if.slave cfg_bus
);

  if (CLEAR_CYCLES < 1 || CLEAR_CYCLES > 15) begin : g_bad_clear
    $error("CLEAR_CYCLES out of range 1..15");
  end
  if (QUIET_CYCLES < 1 || QUIET_CYCLES > 255) begin : g_bad_quiet
    $error("QUIET_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  typedef enum logic [2:0] {
    StIdle, StCheck, StDrain, StClear, StWrN, StWrM, StWrCfg, StDone
  } state_e;

  state_e      r_state, w_state_next;
  logic [15:0] r_n, r_m;
  logic [31:0] r_cfg;
  logic        r_in_pkt_i, r_in_pkt_o;
  logic [7:0]  r_quiet_cnt, w_quiet_cnt_next;
  logic [3:0]  r_clear_cnt, w_clear_cnt_next;

  logic        r_req_ready, r_hold, r_clear, r_set_stb, r_done, r_err_range, r_busy;
  logic [7:0]  r_set_addr, w_set_addr_next;
  logic [31:0] r_set_data, w_set_data_next;
  logic        w_err_range_next;

  logic        w_accept, w_range_ok, w_quiet, w_to_hit;

  assign w_accept   = cfg_bus.req_valid & r_req_ready;
  assign w_range_ok = (r_n != 16'd0) && ({16'd0, r_n} <= MAX_N) &&
                      (r_m != 16'd0) && ({16'd0, r_m} <= MAX_M);
  // Any input beat during DRAIN is an upstream violation and re-arms the quiet count too.
  assign w_quiet    = ~r_in_pkt_i & ~r_in_pkt_o & ~cfg_bus.o_tvalid & ~cfg_bus.i_tvalid;

`ifdef RATE_CFG_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err_timeout;

  assign w_to_hit = (r_state == StDrain) && (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt      <= 16'd0;
      r_err_timeout <= 1'b0;
    end else begin
      if (r_state == StDrain) r_to_cnt <= r_to_cnt + 16'd1;
      else                    r_to_cnt <= 16'd0;
      if (w_accept)           r_err_timeout <= 1'b0;
      else if (w_to_hit)      r_err_timeout <= 1'b1;
    end
  end

  assign cfg_bus.err_timeout = r_err_timeout;
`else
  assign w_to_hit            = 1'b0;
  assign cfg_bus.err_timeout = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    w_state_next     = r_state;
    w_quiet_cnt_next = r_quiet_cnt;
    w_clear_cnt_next = r_clear_cnt;
    w_err_range_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StCheck;
      end
      StCheck: begin
        w_quiet_cnt_next = 8'd0;
        if (w_range_ok) begin
          w_state_next = StDrain;
        end else begin
          w_state_next     = StIdle;
          w_err_range_next = 1'b1;
        end
      end
      StDrain: begin
        w_clear_cnt_next = 4'd0;
        if (!w_quiet) begin
          w_quiet_cnt_next = 8'd0;
        end else if (r_quiet_cnt == 8'(QUIET_CYCLES - 1)) begin
          w_state_next = StClear;
        end else begin
          w_quiet_cnt_next = r_quiet_cnt + 8'd1;
        end
        if (w_to_hit) w_state_next = StClear;
      end
      StClear: begin
        if (r_clear_cnt == 4'(CLEAR_CYCLES - 1)) w_state_next = StWrN;
        else                                     w_clear_cnt_next = r_clear_cnt + 4'd1;
      end
      StWrN:   w_state_next = StWrM;
      StWrM:   w_state_next = StWrCfg;
      StWrCfg: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Settings bus keeps its last address/data between writes.
  always_comb begin
    w_set_addr_next = r_set_addr;
    w_set_data_next = r_set_data;
    unique case (w_state_next)
      StWrN: begin
        w_set_addr_next = SR_N_ADDR;
        w_set_data_next = {16'd0, r_n};
      end
      StWrM: begin
        w_set_addr_next = SR_M_ADDR;
        w_set_data_next = {16'd0, r_m};
      end
      StWrCfg: begin
        w_set_addr_next = SR_CONFIG_ADDR;
        w_set_data_next = r_cfg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_quiet_cnt <= 8'd0;
      r_clear_cnt <= 4'd0;
      r_req_ready <= 1'b1;
      r_hold      <= 1'b0;
      r_clear     <= 1'b0;
      r_set_stb   <= 1'b0;
      r_set_addr  <= 8'd0;
      r_set_data  <= 32'd0;
      r_done      <= 1'b0;
      r_err_range <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_quiet_cnt <= w_quiet_cnt_next;
      r_clear_cnt <= w_clear_cnt_next;
      r_req_ready <= (w_state_next == StIdle);
      r_hold      <= (w_state_next != StIdle) && (w_state_next != StCheck);
      r_clear     <= (w_state_next == StClear);
      r_set_stb   <= (w_state_next == StWrN) || (w_state_next == StWrM) ||
                     (w_state_next == StWrCfg);
      r_set_addr  <= w_set_addr_next;
      r_set_data  <= w_set_data_next;
      r_done      <= (w_state_next == StDone);
      r_err_range <= w_err_range_next;
      r_busy      <= (w_state_next != StIdle);
    end
  end

  // Request fields are captured on accept and stay stable for the whole sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n   <= 16'd0;
      r_m   <= 16'd0;
      r_cfg <= 32'd0;
    end else if (w_accept) begin
      r_n   <= cfg_bus.req_n;
      r_m   <= cfg_bus.req_m;
      r_cfg <= cfg_bus.req_config;
    end
  end

  // Packet tracking on both snooped streams; CLEAR flushes axi_rate_change, so forget them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in_pkt_i <= 1'b0;
      r_in_pkt_o <= 1'b0;
    end else if (r_state == StClear) begin
      r_in_pkt_i <= 1'b0;
      r_in_pkt_o <= 1'b0;
    end else begin
      if (cfg_bus.i_tvalid & cfg_bus.i_tready) r_in_pkt_i <= ~cfg_bus.i_tlast;
      if (cfg_bus.o_tvalid & cfg_bus.o_tready) r_in_pkt_o <= ~cfg_bus.o_tlast;
    end
  end

  assign cfg_bus.req_ready = r_req_ready;
  assign cfg_bus.hold      = r_hold;
  assign cfg_bus.clear     = r_clear;
  assign cfg_bus.set_stb   = r_set_stb;
  assign cfg_bus.set_addr  = r_set_addr;
  assign cfg_bus.set_data  = r_set_data;
  assign cfg_bus.done      = r_done;
  assign cfg_bus.err_range = r_err_range;
  assign cfg_bus.busy      = r_busy;

endmodule

// File: doc/rate_change_cfg_ctrl.md
# rate_change_cfg_ctrl

Reconfiguration sequencer for `axi_rate_change`. It accepts N/M rate requests on a valid/ready port and holds the upstream stream at a packet boundary. It waits for the rate-change output to go quiet, pulses `clear`, then issues settings-bus writes for N, M and CONFIG. Sits between the block's control register file and the `set_*`/`clear` inputs of `axi_rate_change`, so rates are never changed mid-packet.

## Interface
- `MAX_N`, 16, largest legal decimation N
- `MAX_M`, 16, largest legal interpolation M
- `SR_N_ADDR`, 0, settings address for N
- `SR_M_ADDR`, 1, settings address for M
- `SR_CONFIG_ADDR`, 2, settings address for CONFIG
- `CLEAR_CYCLES`, 2, length of `clear` pulse (1..15)
- `QUIET_CYCLES`, 16, consecutive output-idle cycles required before clear (1..255)
- `TIMEOUT_CYCLES`, 65535, drain timeout (used only with the macro)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `req_valid`  in  1  rate change request
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_n`  in  16  requested N
- `req_m`  in  16  requested M
- `req_config`  in  32  CONFIG word
- `i_tvalid`, `i_tready`, `i_tlast`  in  1 each  snoop of the rate-change input
- `o_tvalid`, `o_tready`, `o_tlast`  in  1 each  snoop of the rate-change output
- `hold`  out  1  upstream must deassert `i_tvalid` while high
- `clear`  out  1  to `axi_rate_change.clear`
- `set_stb`  out  1  settings strobe
- `set_addr`  out  8  settings address
- `set_data`  out  32  settings data
- `done`  out  1  one-cycle pulse; sequence finished
- `err_range`  out  1  one-cycle pulse; request rejected
- `err_timeout`  out  1  sticky; drain timed out (macro only, else tied 0)
- `busy`  out  1  FSM not in IDLE

## Operation
- Packet-tracking flags `in_pkt_i` and `in_pkt_o`:
  - Set on `tvalid&tready&~tlast`.
  - Cleared on `tvalid&tready&tlast`.
  - Cleared by `reset` and in CLEAR.
- FSM states:
  - IDLE → CHECK on request accept. Latch `req_n`, `req_m` and `req_config`.
  - CHECK: if n==0, n>MAX_N, m==0 or m>MAX_M, pulse `err_range` and go to IDLE. No writes, no hold. Otherwise go to DRAIN.
  - DRAIN:
    - Assert `hold`. A beat already in flight on the input completes normally.
    - Count consecutive cycles with `~in_pkt_i & ~in_pkt_o & ~o_tvalid`. Any violation resets the count to 0.
    - Count == QUIET_CYCLES → CLEAR.
  - CLEAR: `clear`=1 for exactly CLEAR_CYCLES cycles → WR_N.
  - WR_N / WR_M / WR_CFG: one cycle each, `set_stb`=1 with the matching address and data. N and M are zero-extended to 32 bits.
  - WR_CFG → DONE.
  - DONE: pulse `done`, drop `hold` → IDLE.
- `hold` is high in DRAIN, CLEAR, WR_* and DONE.
- `req_ready` = (state==IDLE). A request with `req_valid` asserted in DONE waits until IDLE.
- Input stream activity after DRAIN starts (upstream protocol violation) re-arms the quiet counter. It never corrupts the sequence.
- `reset` mid-sequence returns to IDLE immediately. Any partially issued writes are not replayed.

## Timing
- Reset values:
  - `req_ready`=1
  - `hold`=0, `clear`=0, `set_stb`=0
  - `set_addr`=0, `set_data`=0
  - `done`=0, `err_range`=0, `err_timeout`=0, `busy`=0
- All outputs are registered.
- Latency from accept to `hold` high: 2 cycles (CHECK, then DRAIN's first registered cycle).
- Best-case accept to `done`: 1 (CHECK) + QUIET_CYCLES + CLEAR_CYCLES + 3 + 1 cycles. With defaults that is 23 cycles.
- `err_range` is asserted in the cycle after CHECK.
- The `set_*` writes occur on consecutive cycles in the order N, M, CONFIG.
- `set_addr`/`set_data` hold their last value when `set_stb`=0.

## Configuration
- `RATE_CFG_TIMEOUT_EN` defined:
  - A 16-bit DRAIN counter runs.
  - Reaching TIMEOUT_CYCLES sets sticky `err_timeout` and forces DRAIN → CLEAR. The sequence then completes normally.
  - `err_timeout` clears only on `reset` or on the next accepted request.
- Not defined:
  - DRAIN waits indefinitely.
  - `err_timeout` is constant 0 and the counter is not synthesized.

## Test plan
- Reset asserted asynchronously mid-WR_M → all outputs at reset values within the same cycle; `req_ready`=1 after release; no further `set_stb`.
- Idle stream, request n=4 m=3 cfg=0x5 → `hold` up 2 cycles after accept, `clear` high 2 cycles, then `set_stb` on 3 consecutive cycles with (0,4), (1,3), (2,5), `done` 23 cycles after accept.
- Request n=0 m=3, then n=17 m=1, then n=4 m=0 → `err_range` pulses for each; no `set_stb`, `clear` or `hold`.
- Request while input packet is 5 of 16 beats in → `clear` not asserted until input `tlast` and output `tlast` are seen plus 16 quiet cycles; data is unbroken.
- Output `tvalid` toggling every 10 cycles during DRAIN → quiet counter never reaches 16; `clear` deferred until the toggling stops.
- With `RATE_CFG_TIMEOUT_EN`, TIMEOUT_CYCLES=100, output stuck mid-packet → `err_timeout` set at cycle 100 of DRAIN, then `clear` and the writes follow; next accepted request clears `err_timeout`.
